// File: rtl/goose_leg_anim.sv
// Leg-animation sequencer for the goose sprite: run-cycle frame stepping on leg_tick,
// jump airtime counting and death freeze, all in the clk_in domain.
module goose_leg_anim #(
    parameter int unsigned NUM_FRAMES      = 4,
    parameter int unsigned FRAME_W         = 2,
    parameter int unsigned TICKS_PER_FRAME = 2,
    parameter int unsigned JUMP_TICKS      = 24
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               leg_tick,
    input  logic               run_en,
    input  logic               jump_req,
    input  logic               hit,
    input  logic               restart,
    output logic [FRAME_W-1:0] frame,
    output logic               airborne,
    output logic [7:0]         air_cnt,
    output logic               dead
);

    localparam int unsigned TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int unsigned AIR_W  = 8;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [AIR_W-1:0]   AIR_LAST   = AIR_W'(JUMP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_JUMP = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [AIR_W-1:0]   air_q, air_d;
    logic               airborne_q, airborne_d;
    logic               dead_q, dead_d;

    // State and output registers
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            tick_q     <= '0;
            air_q      <= '0;
            airborne_q <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            tick_q     <= tick_d;
            air_q      <= air_d;
            airborne_q <= airborne_d;
            dead_q     <= dead_d;
        end
    end

    // Next state; event priority is hit > run_en low > jump_req > leg_tick
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        tick_d     = tick_q;
        air_d      = air_q;
        airborne_d = airborne_q;
        dead_d     = dead_q;

        case (state_q)
            S_IDLE: begin
                frame_d    = '0;
                tick_d     = '0;
                air_d      = '0;
                airborne_d = 1'b0;
                dead_d     = 1'b0;
                if (run_en) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (hit) begin
                    state_d = S_DEAD;
                    dead_d  = 1'b1;
                    tick_d  = '0;
                end else if (!run_en) begin
                    state_d = S_IDLE;
                    frame_d = '0;
                    tick_d  = '0;
                end else if (jump_req) begin
                    state_d    = S_JUMP;
                    frame_d    = FRAME_LAST;
                    tick_d     = '0;
                    air_d      = '0;
                    airborne_d = 1'b1;
                end else if (leg_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FRAME_W'(1);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            S_JUMP: begin
                if (hit) begin
                    state_d    = S_DEAD;
                    dead_d     = 1'b1;
                    air_d      = '0;
                    airborne_d = 1'b0;
                end else if (!run_en) begin
                    state_d    = S_IDLE;
                    frame_d    = '0;
                    air_d      = '0;
                    airborne_d = 1'b0;
                end else if (leg_tick) begin
                    if (air_q == AIR_LAST) begin
                        state_d    = S_RUN;
                        frame_d    = '0;
                        tick_d     = '0;
                        air_d      = '0;
                        airborne_d = 1'b0;
                    end else begin
                        air_d = air_q + AIR_W'(1);
                    end
                end
            end

            S_DEAD: begin
                if (restart) begin
                    state_d = S_IDLE;
                    frame_d = '0;
                    dead_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign frame    = frame_q;
    assign airborne = airborne_q;
    assign air_cnt  = air_q;
    assign dead     = dead_q;

endmodule
